// File: rtl/regfile_wb_arbiter.sv
// ---------------------------------------------------------------------------
// regfile_wb_arbiter
//
// Write-back controller for a 32x32 register file. The file has one write
// port, which it writes on the falling edge of Clk. Two producers share that
// port: requester 0 (ALU result) and requester 1 (memory load). Each uses a
// valid/ready handshake, and a round-robin pointer picks the winner when both
// are valid. The accepted write is registered on the rising edge. RW, BusW and
// RegWr are therefore stable for the whole half-cycle before the regfile's
// falling-edge write.
//
// A 32-bit pending-write scoreboard tracks destinations that have issued but
// not yet been written back. Issue logic uses it to detect RAW hazards on the
// two read addresses.
//
// Optional build macro:
//   WB_FWD_EN - when defined, flags reads that hit the register being written
//               in the current cycle. It also drives the write data on
//               FwdData. When undefined, the forwarding outputs are tied to 0.
//
// Parameters:
//   ZERO_REG   - hard-wired zero register. Writes to it are accepted but never
//                raise RegWr, and it is never marked pending.
//   NREQ_FIRST - requester favoured by the round-robin pointer after reset.
//
// Ports:
//   Clk, Rst_n           clock (rising edge) and async active-low reset
//   Wr0Valid/Ready/Addr/Data   requester 0 write handshake
//   Wr1Valid/Ready/Addr/Data   requester 1 write handshake
//   IssueValid, IssueRd  destination of the instruction issuing this cycle
//   QA, QB               regfile read addresses
//   BusyA, BusyB         pending state of QA / QB
//   Pending              full scoreboard vector
//   RW, BusW, RegWr      registered regfile write port
//   FwdAValid, FwdBValid, FwdData   same-cycle forwarding (WB_FWD_EN)
// ---------------------------------------------------------------------------
module regfile_wb_arbiter #(
    parameter int ZERO_REG   = 31,
    parameter int NREQ_FIRST = 0
) (
    input  logic        Clk,
    input  logic        Rst_n,

    input  logic        Wr0Valid,
    output logic        Wr0Ready,
    input  logic [4:0]  Wr0Addr,
    input  logic [31:0] Wr0Data,

    input  logic        Wr1Valid,
    output logic        Wr1Ready,
    input  logic [4:0]  Wr1Addr,
    input  logic [31:0] Wr1Data,

    input  logic        IssueValid,
    input  logic [4:0]  IssueRd,

    input  logic [4:0]  QA,
    input  logic [4:0]  QB,
    output logic        BusyA,
    output logic        BusyB,
    output logic [31:0] Pending,

    output logic [4:0]  RW,
    output logic [31:0] BusW,
    output logic        RegWr,

    output logic        FwdAValid,
    output logic        FwdBValid,
    output logic [31:0] FwdData
);

    localparam logic [4:0] ZERO_ADDR = 5'(ZERO_REG);
    localparam logic       PTR_INIT  = 1'(NREQ_FIRST);

    // rr_ptr = 0 favours requester 0, rr_ptr = 1 favours requester 1
    logic        rr_ptr;
    logic        grant0;
    logic        grant1;
    logic        accept;
    logic [4:0]  sel_addr;
    logic [31:0] sel_data;

    logic [31:0] pending_q;
    logic [31:0] set_mask;
    logic [31:0] clr_mask;

    logic [4:0]  rw_q;
    logic [31:0] busw_q;
    logic        regwr_q;

    // -----------------------------------------------------------------------
    // Arbitration. Ready is held low while in reset, so no handshake can be
    // seen as complete during reset.
    // -----------------------------------------------------------------------
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (Rst_n) begin
            if (Wr0Valid && (!Wr1Valid || !rr_ptr)) begin
                grant0 = 1'b1;
            end else if (Wr1Valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign Wr0Ready = grant0;
    assign Wr1Ready = grant1;
    assign accept   = grant0 | grant1;
    assign sel_addr = grant0 ? Wr0Addr : Wr1Addr;
    assign sel_data = grant0 ? Wr0Data : Wr1Data;

    // -----------------------------------------------------------------------
    // Scoreboard masks. Set is applied after clear, so an issue and a
    // write-back to the same register in one cycle leave it pending: the
    // issuing instruction is the newer producer.
    // -----------------------------------------------------------------------
    always_comb begin
        set_mask = '0;
        clr_mask = '0;
        if (IssueValid) begin
            set_mask[IssueRd] = 1'b1;
        end
        if (accept) begin
            clr_mask[sel_addr] = 1'b1;
        end
        set_mask[ZERO_ADDR] = 1'b0;
    end

    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            pending_q <= '0;
        end else begin
            pending_q <= (pending_q & ~clr_mask) | set_mask;
        end
    end

    // -----------------------------------------------------------------------
    // Registered write port and round-robin pointer. The async reset drops an
    // in-flight write at once, so the regfile's next falling edge is harmless.
    // RW/BusW only load on a real write. This keeps them quiet for
    // zero-register transfers and idle cycles.
    // -----------------------------------------------------------------------
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            rw_q    <= '0;
            busw_q  <= '0;
            regwr_q <= 1'b0;
            rr_ptr  <= PTR_INIT;
        end else begin
            regwr_q <= accept && (sel_addr != ZERO_ADDR);
            if (accept && (sel_addr != ZERO_ADDR)) begin
                rw_q   <= sel_addr;
                busw_q <= sel_data;
            end
            if (accept) begin
                // favour the requester that did not just win
                rr_ptr <= grant0;
            end
        end
    end

    assign RW      = rw_q;
    assign BusW    = busw_q;
    assign RegWr   = regwr_q;
    assign Pending = pending_q;
    assign BusyA   = pending_q[QA];
    assign BusyB   = pending_q[QB];

    // -----------------------------------------------------------------------
    // Forwarding covers the half-cycle before the falling-edge write, while
    // the regfile read ports still return the old value. The zero register
    // never forwards because RegWr stays low for it.
    // -----------------------------------------------------------------------
`ifdef WB_FWD_EN
    assign FwdAValid = regwr_q && (rw_q == QA);
    assign FwdBValid = regwr_q && (rw_q == QB);
    assign FwdData   = busw_q;
`else
    assign FwdAValid = 1'b0;
    assign FwdBValid = 1'b0;
    assign FwdData   = '0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
Name: regfile_wb_arbiter

Overview:
- Write-back controller for the 32x32 register file (two async read ports, one write port written on negedge Clk).
- Shares the single write port between two producers: requester 0 (ALU result) and requester 1 (memory load), using valid/ready handshakes and round-robin arbitration.
- Keeps a 32-bit pending-write scoreboard so issue logic can detect RAW hazards on the two read addresses.
- Drives RW/BusW/RegWr from posedge registers, so they are stable at the regfile's negedge write.

Parameters:
- ZERO_REG, 31, register index that is hard-wired zero; writes to it complete the handshake but never assert RegWr, and it is never marked pending.
- NREQ_FIRST, 0, requester favoured by the round-robin pointer after reset (0 or 1).

Ports:
- Clk  in  1  system clock; arbiter state updates on posedge.
- Rst_n  in  1  asynchronous active-low reset.
- Wr0Valid  in  1  requester 0 has a write.
- Wr0Ready  out  1  requester 0 accepted this cycle.
- Wr0Addr  in  5  requester 0 destination register.
- Wr0Data  in  32  requester 0 data.
- Wr1Valid, Wr1Ready, Wr1Addr, Wr1Data  same as requester 0, for requester 1.
- IssueValid  in  1  an instruction with a destination is issuing.
- IssueRd  in  5  destination of the issuing instruction.
- QA, QB  in  5 each  read addresses currently presented to the regfile.
- BusyA, BusyB  out  1 each  pending[QA] / pending[QB].
- Pending  out  32  full scoreboard vector.
- RW  out  5  regfile write address (registered).
- BusW  out  32  regfile write data (registered).
- RegWr  out  1  regfile write enable (registered).
- FwdAValid, FwdBValid  out  1 each  forwarding hits (see Optional Feature).
- FwdData  out  32  forwarding data.

Behaviour:
- Reset (Rst_n=0, asynchronous): RegWr=0, RW=0, BusW=0, Pending=0, RR pointer=NREQ_FIRST, Wr0Ready=Wr1Ready=0, Fwd*=0.
  - Reset mid-transfer drops the in-flight write: RegWr falls immediately, before the next negedge.
- Arbitration (combinational):
  - Only one valid: that requester gets ready.
  - Both valid: the requester selected by the pointer gets ready.
  - A handshake occurs when WrXValid and WrXReady are both 1 at posedge.
  - Pointer flips to the other requester after every accepted transfer. No transfer leaves it unchanged.
- Throughput and latency:
  - One write per cycle max.
  - Transfer accepted at posedge N: RW/BusW/RegWr are registered at N and the regfile writes at the negedge between N and N+1.
  - If nothing is accepted at posedge N, RegWr=0 during cycle N.
  - Addr==ZERO_REG: transfer accepted, RegWr=0 for that cycle.
- Requester protocol: a requester holding valid keeps Addr/Data stable until accepted. A losing requester waits at most one cycle (starvation-free).
- Scoreboard, at posedge:
  - IssueValid sets pending[IssueRd], unless IssueRd==ZERO_REG.
  - An accepted write clears pending[Addr].
  - Set and clear of the same register in the same cycle: set wins (newer producer).
  - Clearing a non-pending register has no effect.
  - Pending[ZERO_REG] is always 0.
- BusyA/BusyB are combinational from Pending and QA/QB. They reflect pending state after the posedge update.

Optional Feature:
- WB_FWD_EN defined: FwdAValid = RegWr & (RW==QA); FwdBValid = RegWr & (RW==QB); FwdData = BusW.
  - Covers the half-cycle before the negedge write, when the regfile read ports still return the old value.
  - ZERO_REG never forwards, because RegWr is 0 for it.
- WB_FWD_EN undefined: FwdAValid=FwdBValid=0 and FwdData=0 constantly. No forwarding logic is synthesized.

Test Plan:
- Reset, then Wr0Valid=1, Wr0Addr=5, Wr0Data=0xDEADBEEF for one cycle -> Wr0Ready=1 that cycle; RegWr=1, RW=5, BusW=0xDEADBEEF in the next cycle; regfile[5]=0xDEADBEEF after the negedge; RegWr=0 after that.
- Both valid for 4 cycles (W0 addr 1..4, W1 addr 11..14, each held until accepted) -> grant order 0,1,0,1 with NREQ_FIRST=0; each requester waits no more than one cycle.
- IssueValid, IssueRd=7, then QA=7 -> BusyA=1. Wr1 write to 7 accepted -> Pending[7]=0 the next cycle. Issue of 7 and write of 7 in the same cycle -> Pending[7] stays 1.
- Wr0Addr=31 (ZERO_REG), data 0x1234 -> Wr0Ready=1, RegWr remains 0, regfile[31] unchanged. IssueRd=31 -> Pending stays 0.
- Rst_n pulled low mid-cycle while RegWr=1, RW=9 -> RegWr=0 immediately, regfile[9] unchanged, Pending=0.
- WB_FWD_EN defined: write of 0xCAFEF00D to reg 3 with QA=3, QB=4 -> FwdAValid=1, FwdBValid=0, FwdData=0xCAFEF00D during the write cycle. WB_FWD_EN undefined: FwdAValid, FwdBValid and FwdData are 0 throughout.
